pidp10_console_mem_ctl: RTL and testbench
=========================================

Name: pidp10_console_mem_ctl

Overview:
Arbitrates the KV10 memory bus between the CPU and the PiDP-10 front-panel examine/deposit keys. It sequences console memory operations, latches results for the address/data light rows, and times out non-responding memory (NXM). It sits between the pidp10 console scanner outputs, the CPU memory port and the memory controller.

Parameters:
ADDR_W, 18, memory address width (PDP-10 bits 18:35)
DATA_W, 36, memory word width
TIMEOUT, 255, cycles to wait for mem_ack before declaring NXM (1..65535)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
examine_this  input  1  console key level (debounced)
examine_next  input  1  console key level
deposit_this  input  1  console key level
deposit_next  input  1  console key level
addr_switches  input  ADDR_W  console address switches
data_switches  input  DATA_W  console data switches
cpu_run  input  1  CPU running; console keys ignored while 1
cpu_req  input  1  CPU memory request, held until cpu_ack
cpu_write  input  1  CPU write (1) / read (0)
cpu_addr  input  ADDR_W  CPU address
cpu_wdata  input  DATA_W  CPU write data
cpu_ack  output  1  one-cycle completion pulse to CPU
cpu_nxm  output  1  valid with cpu_ack: access timed out
cpu_rdata  output  DATA_W  read data, valid with cpu_ack
mem_req  output  1  memory request
mem_write  output  1  memory write strobe qualifier
mem_addr  output  ADDR_W  memory address
mem_wdata  output  DATA_W  memory write data
mem_ack  input  1  one-cycle memory completion pulse
mem_rdata  input  DATA_W  memory read data, valid with mem_ack
disp_addr  output  ADDR_W  address shown on console lights
disp_data  output  DATA_W  data shown on console lights
disp_mem_data  output  1  MEMORY DATA light
nxm_err  output  1  console access hit NXM (sticky)
busy  output  1  transfer in progress

Behaviour:
- Reset: every output 0; internal last_addr 0, key history 0, state IDLE. Reset mid-transfer drops mem_req next edge; no ack issued.
- Key edge detect: registered previous level per key; command = level & ~prev. Edges processed only in IDLE with cpu_run=0 and cpu_req=0; otherwise discarded (not queued). Simultaneous edges: priority examine_this > examine_next > deposit_this > deposit_next; others dropped.
- States: IDLE, CPU_XFER, CON_XFER.
- IDLE: cpu_req=1 -> capture cpu_write/addr/wdata onto mem_*, mem_req<=1, CPU_XFER (CPU wins over same-cycle key edge). Else accepted key -> address = addr_switches (this) or last_addr+1 mod 2^ADDR_W (next; 2^18-1 wraps to 0); mem_write=1 for deposit, mem_wdata<=data_switches captured at that edge; nxm_err<=0; mem_req<=1; CON_XFER.
- busy=1 in CPU_XFER and CON_XFER.
- Timeout counter cleared on entry to each XFER, increments per cycle without mem_ack.
- CPU_XFER: mem_ack -> mem_req<=0, cpu_ack<=1 (one cycle, cycle after mem_ack), cpu_rdata<=mem_rdata (reads only; unchanged on write), cpu_nxm<=0, IDLE. Counter==TIMEOUT -> mem_req<=0, cpu_ack<=1, cpu_nxm<=1, IDLE.
- CON_XFER: mem_ack -> mem_req<=0, last_addr<=disp_addr<=mem_addr, disp_data<=mem_rdata (examine) or mem_wdata (deposit), disp_mem_data<=1, IDLE. Timeout -> mem_req<=0, nxm_err<=1, last_addr<=mem_addr, disp_addr<=mem_addr, disp_data unchanged, IDLE.
- mem_ack outside an XFER ignored. Minimum back-to-back: next request issued 1 cycle after returning to IDLE.
- disp_mem_data cleared whenever cpu_run=1.
- Latency: key edge sampled -> mem_req 1 cycle; mem_ack -> disp update 1 cycle.

Test Plan:
- Reset, addr_switches=0o1000, data_switches=0o123456654321, pulse deposit_this -> mem_req, mem_write=1, mem_addr=0o1000; ack after 3 cycles -> disp_addr=0o1000, disp_data=0o123456654321, disp_mem_data=1.
- examine_next held 10 cycles after above, mem_rdata=0o7 -> exactly one read at 0o1001, disp_data=0o7.
- last_addr=0o777777, deposit_next -> mem_addr=0, wraps.
- Console read, never ack -> mem_req drops after 255 cycles, nxm_err=1, disp_data unchanged; next examine_this clears nxm_err.
- cpu_req and examine_this edge same cycle -> CPU served, cpu_ack one cycle after mem_ack with cpu_rdata=mem_rdata; key edge dropped (no second request).
- Assert reset during CON_XFER -> mem_req=0 next cycle, all outputs 0, late mem_ack ignored.

Source files
------------

// File: rtl/pidp10_console_mem_ctl.sv
// rtl/pidp10_console_mem_ctl.sv - KV10 memory bus arbiter for CPU and console examine/deposit keys
//
// Purpose: shares one memory port between the CPU and the front-panel
// examine/deposit keys, latches console results for the light rows and
// times out non-responding memory (NXM).
//
// Ports:
//   clk, reset                  system clock, synchronous active-high reset
//   examine_this/next,
//   deposit_this/next           debounced console key levels
//   addr_switches/data_switches console switch rows
//   cpu_run                     console keys ignored while set
//   cpu_req/write/addr/wdata    CPU request, held until cpu_ack
//   cpu_ack/nxm/rdata           CPU completion pulse, timeout flag, read data
//   mem_req/write/addr/wdata    memory request toward the memory controller
//   mem_ack/rdata               memory completion pulse and read data
//   disp_addr/disp_data         console light rows
//   disp_mem_data               MEMORY DATA light
//   nxm_err                     sticky console NXM flag
//   busy                        transfer in progress
module pidp10_console_mem_ctl #(
  parameter int ADDR_W  = 18,
  parameter int DATA_W  = 36,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              examine_this,
  input  logic              examine_next,
  input  logic              deposit_this,
  input  logic              deposit_next,
  input  logic [ADDR_W-1:0] addr_switches,
  input  logic [DATA_W-1:0] data_switches,
  input  logic              cpu_run,
  input  logic              cpu_req,
  input  logic              cpu_write,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic              cpu_nxm,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              mem_req,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_data,
  output logic              disp_mem_data,
  output logic              nxm_err,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, CPU_XFER, CON_XFER} state_t;

  state_t             state_q, state_d;
  logic [3:0]         key_prev;
  logic [3:0]         key_edge;
  logic [ADDR_W-1:0]  last_addr, last_addr_d;
  logic [15:0]        tcnt, tcnt_d;
  logic               timed_out;

  logic               cpu_ack_d, cpu_nxm_d, mem_req_d, mem_write_d;
  logic               disp_mem_data_d, nxm_err_d;
  logic [DATA_W-1:0]  cpu_rdata_d, mem_wdata_d, disp_data_d;
  logic [ADDR_W-1:0]  mem_addr_d, disp_addr_d;

  // Bit order gives the key priority: examine_this highest.
  assign key_edge  = {examine_this, examine_next, deposit_this, deposit_next} & ~key_prev;
  assign timed_out = (tcnt == 16'(TIMEOUT));

  always_comb begin
    state_d         = state_q;
    last_addr_d     = last_addr;
    tcnt_d          = tcnt + 16'd1;
    cpu_ack_d       = 1'b0;
    cpu_nxm_d       = cpu_nxm;
    cpu_rdata_d     = cpu_rdata;
    mem_req_d       = mem_req;
    mem_write_d     = mem_write;
    mem_addr_d      = mem_addr;
    mem_wdata_d     = mem_wdata;
    disp_addr_d     = disp_addr;
    disp_data_d     = disp_data;
    disp_mem_data_d = disp_mem_data;
    nxm_err_d       = nxm_err;

    case (state_q)
      IDLE: begin
        tcnt_d = '0;
        // CPU wins; key edges arriving while it is served are simply lost.
        if (cpu_req) begin
          mem_req_d   = 1'b1;
          mem_write_d = cpu_write;
          mem_addr_d  = cpu_addr;
          mem_wdata_d = cpu_wdata;
          state_d     = CPU_XFER;
        end else if (!cpu_run && (key_edge != 4'b0000)) begin
          mem_req_d = 1'b1;
          nxm_err_d = 1'b0;
          state_d   = CON_XFER;
          if (key_edge[3]) begin
            mem_addr_d  = addr_switches;
            mem_write_d = 1'b0;
          end else if (key_edge[2]) begin
            mem_addr_d  = last_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
            mem_write_d = 1'b0;
          end else if (key_edge[1]) begin
            mem_addr_d  = addr_switches;
            mem_write_d = 1'b1;
            mem_wdata_d = data_switches;
          end else begin
            mem_addr_d  = last_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
            mem_write_d = 1'b1;
            mem_wdata_d = data_switches;
          end
        end
      end

      CPU_XFER: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          cpu_ack_d = 1'b1;
          cpu_nxm_d = 1'b0;
          if (!mem_write) cpu_rdata_d = mem_rdata;
          state_d   = IDLE;
        end else if (timed_out) begin
          mem_req_d = 1'b0;
          cpu_ack_d = 1'b1;
          cpu_nxm_d = 1'b1;
          state_d   = IDLE;
        end
      end

      CON_XFER: begin
        if (mem_ack) begin
          mem_req_d       = 1'b0;
          last_addr_d     = mem_addr;
          disp_addr_d     = mem_addr;
          disp_data_d     = mem_write ? mem_wdata : mem_rdata;
          disp_mem_data_d = 1'b1;
          state_d         = IDLE;
        end else if (timed_out) begin
          // The lights keep the old data but show the failing address.
          mem_req_d   = 1'b0;
          nxm_err_d   = 1'b1;
          last_addr_d = mem_addr;
          disp_addr_d = mem_addr;
          state_d     = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    if (cpu_run) disp_mem_data_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      key_prev      <= '0;
      last_addr     <= '0;
      tcnt          <= '0;
      cpu_ack       <= 1'b0;
      cpu_nxm       <= 1'b0;
      cpu_rdata     <= '0;
      mem_req       <= 1'b0;
      mem_write     <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      disp_addr     <= '0;
      disp_data     <= '0;
      disp_mem_data <= 1'b0;
      nxm_err       <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state_q       <= state_d;
      key_prev      <= {examine_this, examine_next, deposit_this, deposit_next};
      last_addr     <= last_addr_d;
      tcnt          <= tcnt_d;
      cpu_ack       <= cpu_ack_d;
      cpu_nxm       <= cpu_nxm_d;
      cpu_rdata     <= cpu_rdata_d;
      mem_req       <= mem_req_d;
      mem_write     <= mem_write_d;
      mem_addr      <= mem_addr_d;
      mem_wdata     <= mem_wdata_d;
      disp_addr     <= disp_addr_d;
      disp_data     <= disp_data_d;
      disp_mem_data <= disp_mem_data_d;
      nxm_err       <= nxm_err_d;
      busy          <= (state_d != IDLE);
    end
  end

endmodule

// File: tb/tb_pidp10_console_mem_ctl.sv
// tb/tb_pidp10_console_mem_ctl.sv - directed self-checking bench for pidp10_console_mem_ctl
module tb_pidp10_console_mem_ctl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        examine_this = 1'b0, examine_next = 1'b0;
  logic        deposit_this = 1'b0, deposit_next = 1'b0;
  logic [17:0] addr_switches = '0;
  logic [35:0] data_switches = '0;
  logic        cpu_run = 1'b0, cpu_req = 1'b0, cpu_write = 1'b0;
  logic [17:0] cpu_addr = '0;
  logic [35:0] cpu_wdata = '0;
  logic        cpu_ack, cpu_nxm;
  logic [35:0] cpu_rdata;
  logic        mem_req, mem_write;
  logic [17:0] mem_addr;
  logic [35:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [35:0] mem_rdata = '0;
  logic [17:0] disp_addr;
  logic [35:0] disp_data;
  logic        disp_mem_data, nxm_err, busy;

  int total = 0;
  int bad = 0;

  pidp10_console_mem_ctl dut (
    .clk(clk), .reset(reset),
    .examine_this(examine_this), .examine_next(examine_next),
    .deposit_this(deposit_this), .deposit_next(deposit_next),
    .addr_switches(addr_switches), .data_switches(data_switches),
    .cpu_run(cpu_run), .cpu_req(cpu_req), .cpu_write(cpu_write),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_nxm(cpu_nxm), .cpu_rdata(cpu_rdata),
    .mem_req(mem_req), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .disp_addr(disp_addr), .disp_data(disp_data), .disp_mem_data(disp_mem_data),
    .nxm_err(nxm_err), .busy(busy)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled just after the falling edge.
  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic ack_once();
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(2);
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL reset_mem_req got=%b want=0", mem_req); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if ({disp_addr, disp_data} !== 54'd0) begin bad++; $display("FAIL reset_disp got=%o/%o want=0/0", disp_addr, disp_data); end
    total++; if ({disp_mem_data, nxm_err, cpu_ack, cpu_nxm} !== 4'b0000) begin bad++; $display("FAIL reset_flags got=%b want=0000", {disp_mem_data, nxm_err, cpu_ack, cpu_nxm}); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_deposit_this();
    addr_switches = 18'o001000;
    data_switches = 36'o123456654321;
    deposit_this = 1'b1;
    step();
    deposit_this = 1'b0;
    total++; if ({mem_req, mem_write, busy} !== 3'b111) begin bad++; $display("FAIL dep_req got=%b want=111", {mem_req, mem_write, busy}); end
    total++; if (mem_addr !== 18'o001000) begin bad++; $display("FAIL dep_addr got=%o want=1000", mem_addr); end
    total++; if (mem_wdata !== 36'o123456654321) begin bad++; $display("FAIL dep_wdata got=%o want=123456654321", mem_wdata); end
    step(2);
    ack_once();
    total++; if (disp_addr !== 18'o001000) begin bad++; $display("FAIL dep_disp_addr got=%o want=1000", disp_addr); end
    total++; if (disp_data !== 36'o123456654321) begin bad++; $display("FAIL dep_disp_data got=%o want=123456654321", disp_data); end
    total++; if ({disp_mem_data, mem_req, busy} !== 3'b100) begin bad++; $display("FAIL dep_done got=%b want=100", {disp_mem_data, mem_req, busy}); end
  endtask

  task automatic test_examine_next_held();
    int extra;
    extra = 0;
    mem_rdata = 36'o7;
    examine_next = 1'b1;
    step();
    total++; if ({mem_req, mem_write} !== 2'b10) begin bad++; $display("FAIL exn_req got=%b want=10", {mem_req, mem_write}); end
    total++; if (mem_addr !== 18'o001001) begin bad++; $display("FAIL exn_addr got=%o want=1001", mem_addr); end
    ack_once();
    total++; if (disp_data !== 36'o7) begin bad++; $display("FAIL exn_data got=%o want=7", disp_data); end
    total++; if (disp_addr !== 18'o001001) begin bad++; $display("FAIL exn_disp_addr got=%o want=1001", disp_addr); end
    for (int i = 0; i < 8; i++) begin
      step();
      if (mem_req) extra++;
    end
    total++; if (extra !== 0) begin bad++; $display("FAIL exn_single got=%0d want=0 extra request cycles", extra); end
    examine_next = 1'b0;
    step();
  endtask

  task automatic test_wrap();
    addr_switches = 18'o777777;
    examine_this = 1'b1;
    step();
    examine_this = 1'b0;
    ack_once();
    data_switches = 36'o42;
    deposit_next = 1'b1;
    step();
    deposit_next = 1'b0;
    total++; if ({mem_req, mem_write} !== 2'b11) begin bad++; $display("FAIL wrap_req got=%b want=11", {mem_req, mem_write}); end
    total++; if (mem_addr !== 18'o000000) begin bad++; $display("FAIL wrap_addr got=%o want=0", mem_addr); end
    ack_once();
    total++; if ({disp_addr, disp_data} !== {18'o0, 36'o42}) begin bad++; $display("FAIL wrap_disp got=%o/%o want=0/42", disp_addr, disp_data); end
  endtask

  task automatic test_nxm();
    int n;
    n = 0;
    addr_switches = 18'o000555;
    examine_this = 1'b1;
    step();
    examine_this = 1'b0;
    for (int i = 0; i < 400 && mem_req; i++) begin
      n++;
      step();
    end
    total++; if (n < 255 || n > 256) begin bad++; $display("FAIL nxm_req_cycles got=%0d want=255..256", n); end
    total++; if ({nxm_err, busy} !== 2'b10) begin bad++; $display("FAIL nxm_flag got=%b want=10", {nxm_err, busy}); end
    total++; if (disp_data !== 36'o42) begin bad++; $display("FAIL nxm_data_kept got=%o want=42", disp_data); end
    total++; if (disp_addr !== 18'o000555) begin bad++; $display("FAIL nxm_disp_addr got=%o want=555", disp_addr); end
    mem_rdata = 36'o66;
    examine_this = 1'b1;
    step();
    examine_this = 1'b0;
    total++; if ({nxm_err, mem_req} !== 2'b01) begin bad++; $display("FAIL nxm_clear got=%b want=01", {nxm_err, mem_req}); end
    ack_once();
    total++; if ({disp_data, disp_mem_data} !== {36'o66, 1'b1}) begin bad++; $display("FAIL nxm_recover got=%o/%b want=66/1", disp_data, disp_mem_data); end
  endtask

  task automatic test_cpu_vs_key();
    int extra;
    extra = 0;
    cpu_req = 1'b1; cpu_write = 1'b0; cpu_addr = 18'o004321;
    addr_switches = 18'o000100;
    examine_this = 1'b1;
    step();
    total++; if ({mem_req, mem_write, mem_addr} !== {2'b10, 18'o004321}) begin bad++; $display("FAIL cpu_req got=%b%b %o want=10 4321", mem_req, mem_write, mem_addr); end
    mem_rdata = 36'o1234567;
    step();
    total++; if (cpu_ack !== 1'b0) begin bad++; $display("FAIL cpu_ack_early got=%b want=0", cpu_ack); end
    ack_once();
    total++; if ({cpu_ack, cpu_nxm} !== 2'b10) begin bad++; $display("FAIL cpu_ack got=%b want=10", {cpu_ack, cpu_nxm}); end
    total++; if (cpu_rdata !== 36'o1234567) begin bad++; $display("FAIL cpu_rdata got=%o want=1234567", cpu_rdata); end
    cpu_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (mem_req || cpu_ack) extra++;
    end
    total++; if (extra !== 0) begin bad++; $display("FAIL cpu_key_dropped got=%0d want=0 stray cycles", extra); end
    examine_this = 1'b0;
    step();
  endtask

  task automatic test_cpu_run();
    cpu_run = 1'b1;
    examine_this = 1'b1;
    step();
    total++; if ({mem_req, disp_mem_data} !== 2'b00) begin bad++; $display("FAIL run_ignore got=%b want=00", {mem_req, disp_mem_data}); end
    examine_this = 1'b0;
    cpu_run = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    addr_switches = 18'o000200;
    examine_this = 1'b1;
    step();
    total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL mid_req got=%b want=1", mem_req); end
    reset = 1'b1;
    step();
    examine_this = 1'b0;
    total++; if ({mem_req, busy, nxm_err, disp_mem_data} !== 4'b0000) begin bad++; $display("FAIL mid_reset got=%b want=0000", {mem_req, busy, nxm_err, disp_mem_data}); end
    total++; if ({disp_addr, disp_data} !== 54'd0) begin bad++; $display("FAIL mid_reset_disp got=%o/%o want=0/0", disp_addr, disp_data); end
    reset = 1'b0;
    mem_rdata = 36'o777;
    ack_once();
    step();
    total++; if ({disp_data, disp_mem_data, mem_req, busy, cpu_ack} !== {36'd0, 4'b0000}) begin bad++; $display("FAIL late_ack got=%o %b want=0 0000", disp_data, {disp_mem_data, mem_req, busy, cpu_ack}); end
  endtask

  initial begin
    test_reset();
    test_deposit_this();
    test_examine_next_held();
    test_wrap();
    test_nxm();
    test_cpu_run();
    test_cpu_vs_key();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
